// File: rtl/count_lead_unit.sv
// count_lead_unit: multi-cycle leading-zero / leading-one counter.
// Ports: Clk, Reset (sync, active-low), Start, Mode (0=CLZ, 1=CLO), A -> Busy, Done, Count.
module count_lead_unit #(
  parameter int WIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Mode,
  input  logic [WIDTH-1:0]         A,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH):0]   Count
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    count_n;
  logic             done_n;
  logic             busy_n;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      Count <= '0;
      Done  <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      Count <= count_n;
      Done  <= done_n;
      Busy  <= busy_n;
    end
  end

  // CLO is folded into CLZ by inverting the operand at capture.
  // The cnt==WMAX term ends the scan of an all-zero shreg
  // before the counter could wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    count_n = Count;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_n = SCAN;
          cnt_n   = '0;
          shreg_n = Mode ? ~A : A;
        end
      end
      SCAN: begin
        if (shreg[WIDTH-1] || (cnt == WMAX)) begin
          count_n = cnt;
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n   = cnt + 1'b1;
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
